rr_arbiter4: RTL and testbench

Four-requester arbiter that sequences access to one shared resource. Each cycle in which the resource is free it picks one requester from `req[3:0]`, in either fixed-priority or round-robin order, and holds that grant until the owner releases it or a hold timeout expires. A combinational 4-to-2 priority encoder selects the winner. The arbiter sits between requesting engines and the shared datapath and drives its select/enable.

---
 rtl/arb_pkg.sv | 18 +
 rtl/pri_enc4.sv | 28 ++
 rtl/rr_arbiter4.sv | 109 ++++++++++
 tb/tb_rr_arbiter4.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants and FSM state encoding for rr_arbiter4.
// Revision    : 1.0
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/pri_enc4.sv
`default_nettype none
// ============================================================================
// Module      : pri_enc4
// Description : Combinational 4-to-2 priority encoder, highest set index wins.
// Revision    : 1.0
// ============================================================================
module pri_enc4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] x,
    input  logic             en,
    output logic [ID_W-1:0]  y,
    output logic             z
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (x[i]) begin
                y = ID_W'(i);
            end
        end
    end

    assign z = en & (|x);

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-requester fixed-priority / round-robin arbiter with a
//               grant hold timeout and registered one-hot grant outputs.
// Revision    : 1.0
// ============================================================================
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int                   c_hold_w    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [c_hold_w-1:0]  c_hold_one  = c_hold_w'(1);
    localparam logic [N_REQ-1:0]     c_one_hot0  = N_REQ'(1);

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [c_hold_w-1:0] r_hold;
    logic [N_REQ-1:0]    r_skip;

    logic [N_REQ-1:0]    w_cand;
    logic [2*N_REQ-1:0]  w_dbl;
    logic [N_REQ-1:0]    w_enc_in;
    logic [ID_W-1:0]     w_enc_y;
    logic                w_enc_z;
    logic [ID_W-1:0]     w_winner;
    logic                w_owner_req;
    logic                w_hold_expired;

    assign w_cand = req & ~r_skip;

    // r_ptr holds the last winner: rotating right by it puts r_ptr-1 on top
    // of the encoder and the last winner itself at the bottom.
    assign w_dbl    = {w_cand, w_cand} >> r_ptr;
    assign w_enc_in = mode ? w_dbl[N_REQ-1:0] : w_cand;

    pri_enc4 u_enc (
        .x  (w_enc_in),
        .en (en),
        .y  (w_enc_y),
        .z  (w_enc_z)
    );

    assign w_winner       = mode ? (w_enc_y + r_ptr) : w_enc_y;
    assign w_owner_req    = req[gnt_id];
    assign w_hold_expired = (MAX_HOLD != 0) && (r_hold == c_hold_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_skip    <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_skip <= '0;
                    r_hold <= '0;
                    if (w_enc_z) begin
                        gnt       <= c_one_hot0 << w_winner;
                        gnt_id    <= w_winner;
                        gnt_valid <= 1'b1;
                        r_ptr     <= w_winner;
                        r_state   <= GRANT;
                    end
                end
                GRANT: begin
                    // A release on the expiry edge takes precedence over the timeout.
                    if (!w_owner_req) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        r_hold    <= '0;
                        r_state   <= IDLE;
                    end else if (w_hold_expired) begin
                        gnt            <= '0;
                        gnt_valid      <= 1'b0;
                        r_hold         <= '0;
                        timeout        <= 1'b1;
                        r_skip[gnt_id] <= 1'b1;
                        r_state        <= IDLE;
                    end else begin
                        r_hold <= r_hold + c_hold_one;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter4
// Description : Self-checking bench for rr_arbiter4 with a behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_rr_arbiter4;
    import arb_pkg::*;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt, gnt3;
    logic [1:0] gnt_id, gnt_id3;
    logic       gnt_valid, gnt_valid3, timeout, timeout3;

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 when free), cycles held, last winner, skip mask
    int         m_owner;
    int         m_held;
    int         m_last;
    logic [3:0] m_skip;
    logic       m_to;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(MH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    rr_arbiter4 #(.MAX_HOLD(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req),
        .gnt(gnt3), .gnt_id(gnt_id3), .gnt_valid(gnt_valid3), .timeout(timeout3)
    );

    function automatic logic [3:0] m_gnt();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 0;
        m_skip  = 4'b0000;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic md, input logic [3:0] r);
        int         win;
        logic [3:0] elig;
        m_to = 1'b0;
        if (m_owner < 0) begin
            elig   = r & ~m_skip;
            m_skip = 4'b0000;
            win    = -1;
            if (e && elig != 4'b0000) begin
                if (!md) begin
                    for (int i = 0; i < 4; i++) if (elig[i]) win = i;
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        int c;
                        c = (m_last + 4 - k) % 4;
                        if (win < 0 && elig[c]) win = c;
                    end
                end
                m_owner = win;
                m_last  = win;
                m_held  = 1;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (MH != 0 && m_held == MH) begin
            m_skip[m_owner] = 1'b1;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic tick(input logic e, input logic md, input logic [3:0] r);
        en   = e;
        mode = md;
        req  = r;
        @(posedge clk);
        model_step(e, md, r);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: observed gnt=%b id=%0d v=%b to=%b expected all zero", gnt, gnt_id, gnt_valid, timeout);
        end
        rst = 1'b0;
        tick(1'b1, 1'b0, 4'b0100);
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: observed gnt=%b id=%0d v=%b expected gnt=0100 id=2 v=1", gnt, gnt_id, gnt_valid);
        end
        tick(1'b1, 1'b0, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_async: observed gnt=%b id=%0d v=%b to=%b expected all zero", gnt, gnt_id, gnt_valid, timeout);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fixed_repeat();
        apply_reset();
        for (int n = 0; n < 3; n++) begin
            tick(1'b1, 1'b0, 4'b1011);
            tick(1'b1, 1'b0, 4'b1011);
            checks++;
            if (gnt !== 4'b1000 || gnt_id !== 2'd3 || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL fixed_repeat round %0d: observed gnt=%b id=%0d v=%b expected gnt=1000 id=3 v=1", n, gnt, gnt_id, gnt_valid);
            end
            tick(1'b1, 1'b0, 4'b0011);
            checks++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL fixed_idle round %0d: observed gnt=%b v=%b expected gnt=0000 v=0", n, gnt, gnt_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{3, 2, 1, 0, 3};
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            tick(1'b1, 1'b1, 4'b1111);
            checks++;
            if (gnt_valid !== 1'b1 || gnt_id !== 2'(exp_id[n]) || gnt !== 4'(1 << exp_id[n])) begin
                errors++;
                $display("FAIL rr_order step %0d: observed gnt=%b id=%0d v=%b expected id=%0d v=1", n, gnt, gnt_id, gnt_valid, exp_id[n]);
            end
            tick(1'b1, 1'b1, 4'b1111 & ~4'(1 << exp_id[n]));
            checks++;
            if (gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap step %0d: observed v=%b expected v=0", n, gnt_valid);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_g;
        logic       exp_t;
        apply_reset();
        for (int t = 1; t <= 11; t++) begin
            tick(1'b1, 1'b0, 4'b1001);
            exp_g = (t <= 4) ? 4'b1000 : (t == 5) ? 4'b0000 : (t <= 9) ? 4'b0001 : (t == 10) ? 4'b0000 : 4'b1000;
            exp_t = (t == 5) || (t == 10);
            checks++;
            if (gnt !== exp_g || timeout !== exp_t || gnt_valid !== (exp_g != 4'b0000)) begin
                errors++;
                $display("FAIL timeout cycle %0d: observed gnt=%b to=%b v=%b expected gnt=%b to=%b", t, gnt, timeout, gnt_valid, exp_g, exp_t);
            end
        end
    endtask

    task automatic test_enable();
        apply_reset();
        for (int n = 0; n < 3; n++) begin
            tick(1'b0, 1'b0, 4'b0010);
            checks++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL enable_block %0d: observed gnt=%b v=%b expected gnt=0000 v=0", n, gnt, gnt_valid);
            end
        end
        tick(1'b1, 1'b0, 4'b0010);
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL enable_grant: observed gnt=%b id=%0d expected gnt=0010 id=1", gnt, gnt_id);
        end
        for (int n = 0; n < 2; n++) begin
            tick(1'b0, 1'b0, 4'b0010);
            checks++;
            if (gnt !== 4'b0010) begin
                errors++;
                $display("FAIL enable_hold %0d: observed gnt=%b expected gnt=0010", n, gnt);
            end
        end
        tick(1'b0, 1'b0, 4'b0000);
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_release: observed gnt=%b v=%b expected gnt=0000 v=0", gnt, gnt_valid);
        end
    endtask

    task automatic test_release_vs_timeout();
        apply_reset();
        tick(1'b1, 1'b0, 4'b0001);
        tick(1'b1, 1'b0, 4'b0001);
        tick(1'b1, 1'b0, 4'b0001);
        checks++;
        if (gnt3 !== 4'b0001) begin
            errors++;
            $display("FAIL coincide_hold: observed gnt=%b expected gnt=0001", gnt3);
        end
        tick(1'b1, 1'b0, 4'b0000);
        checks++;
        if (gnt3 !== 4'b0000 || timeout3 !== 1'b0) begin
            errors++;
            $display("FAIL coincide_release: observed gnt=%b to=%b expected gnt=0000 to=0", gnt3, timeout3);
        end
        tick(1'b1, 1'b0, 4'b0001);
        checks++;
        if (gnt3 !== 4'b0001 || gnt_valid3 !== 1'b1) begin
            errors++;
            $display("FAIL coincide_noskip: observed gnt=%b v=%b expected gnt=0001 v=1", gnt3, gnt_valid3);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       md;
        apply_reset();
        r  = 4'b0000;
        md = 1'b0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
            if ($urandom_range(0, 15) == 0) md = ~md;
            tick($urandom_range(0, 7) != 0, md, r);
            checks++;
            if (gnt !== m_gnt() || gnt_valid !== (m_owner >= 0) || timeout !== m_to ||
                (m_owner >= 0 && gnt_id !== 2'(m_owner))) begin
                errors++;
                $display("FAIL random cycle %0d: observed gnt=%b id=%0d v=%b to=%b expected gnt=%b owner=%0d to=%b",
                         n, gnt, gnt_id, gnt_valid, timeout, m_gnt(), m_owner, m_to);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed_repeat();
        test_round_robin();
        test_timeout();
        test_enable();
        test_release_vs_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
